// File: rtl/flag_pkg.sv
// flag_pkg
// Shared types for the ALU flag path: the 4-bit condition code encoding,
// the NZCV flag struct, the result register state, and the condition
// evaluation function used by cond_check.
package flag_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic {
    RES_EMPTY = 1'b0,
    RES_FULL  = 1'b1
  } res_state_e;

  function automatic logic cond_pass(cond_e cond, flags_t f);
    logic pass;
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = f.z;
      COND_NE: pass = !f.z;
      COND_CS: pass = f.c;
      COND_CC: pass = !f.c;
      COND_MI: pass = f.n;
      COND_PL: pass = !f.n;
      COND_VS: pass = f.v;
      COND_VC: pass = !f.v;
      COND_HI: pass = f.c && !f.z;
      COND_LS: pass = !f.c || f.z;
      COND_GE: pass = (f.n == f.v);
      COND_LT: pass = (f.n != f.v);
      COND_GT: pass = !f.z && (f.n == f.v);
      COND_LE: pass = f.z || (f.n != f.v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/flag_eval_cond_check.sv
// cond_check
// Purely combinational evaluation of one condition code against a flag set.
// Ports:
//   i_cond  - condition code to evaluate
//   i_flags - flags to evaluate against
//   o_pass  - 1 when the condition holds
module cond_check
  import flag_pkg::*;
(
  input  cond_e  i_cond,
  input  flags_t i_flags,
  output logic   o_pass
);

  always_comb begin
    o_pass = cond_pass(i_cond, i_flags);
  end

endmodule

// File: rtl/flag_eval.sv
// flag_eval
// Holds the NZCV flag register written by the compare unit, counts
// flag-setting ops still in flight, and answers condition queries through a
// valid/ready handshake with a one-entry registered result.
// Ports:
//   i_clk, i_rst               - clock, synchronous active-high reset
//   i_issue                    - flag-setting op issued this cycle
//   i_wb_valid, i_wb_{n,z,c,v} - flag writeback from the compare unit
//   i_q_valid, o_q_ready, i_q_cond      - condition query handshake
//   o_r_valid, i_r_ready, o_r_taken, o_r_cond - result handshake
//   o_flags                    - flag register {N,Z,C,V}
//   o_issue_stall              - in-flight counter is full
//   o_err                      - sticky protocol error
module flag_eval
  import flag_pkg::*;
#(
  parameter int MAX_PENDING = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_issue,
  input  logic       i_wb_valid,
  input  logic       i_wb_n,
  input  logic       i_wb_z,
  input  logic       i_wb_c,
  input  logic       i_wb_v,
  input  logic       i_q_valid,
  output logic       o_q_ready,
  input  logic [3:0] i_q_cond,
  output logic       o_r_valid,
  input  logic       i_r_ready,
  output logic       o_r_taken,
  output logic [3:0] o_r_cond,
  output logic [3:0] o_flags,
  output logic       o_issue_stall,
  output logic       o_err
);

  localparam int CW = $clog2(MAX_PENDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PENDING);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  logic [CW-1:0] pending_q, pending_d;
  flags_t        flags_q, flags_d;
  res_state_e    state_q, state_d;
  logic          taken_q, taken_d;
  logic [3:0]    cond_q, cond_d;
  logic          err_q, err_d;

  flags_t wb_flags;
  flags_t flags_eff;
  logic   q_accept;
  logic   cond_ok;

  assign wb_flags  = '{n: i_wb_n, z: i_wb_z, c: i_wb_c, v: i_wb_v};
  // Same-cycle writeback bypasses the flag register for queries.
  assign flags_eff = i_wb_valid ? wb_flags : flags_q;

  cond_check u_cond_check (
    .i_cond  (cond_e'(i_q_cond)),
    .i_flags (flags_eff),
    .o_pass  (cond_ok)
  );

  // A query may only see final flags: nothing in flight, or the last op
  // completing this cycle. A same-cycle issue is younger and is ignored here.
  always_comb begin
    o_q_ready = ((pending_q == '0) || ((pending_q == ONE_CNT) && i_wb_valid))
                && ((state_q == RES_EMPTY) || i_r_ready);
    q_accept  = i_q_valid && o_q_ready;
  end

  // In-flight counter, flag register and sticky error.
  always_comb begin
    pending_d = pending_q;
    flags_d   = flags_q;
    err_d     = err_q;
    if (i_wb_valid) begin
      flags_d = wb_flags;
    end
    case ({i_issue, i_wb_valid})
      2'b10: begin
        if (pending_q == MAX_CNT) err_d = 1'b1;
        else                      pending_d = pending_q + ONE_CNT;
      end
      2'b01: begin
        if (pending_q == '0) err_d = 1'b1;
        else                 pending_d = pending_q - ONE_CNT;
      end
      default: pending_d = pending_q;
    endcase
  end

  // Result register: an accept always (re)loads it; otherwise a consumed
  // result empties it and an unconsumed one holds.
  always_comb begin
    state_d = state_q;
    taken_d = taken_q;
    cond_d  = cond_q;
    if (q_accept) begin
      state_d = RES_FULL;
      taken_d = cond_ok;
      cond_d  = i_q_cond;
    end else if ((state_q == RES_FULL) && i_r_ready) begin
      state_d = RES_EMPTY;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pending_q <= '0;
      flags_q   <= '0;
      state_q   <= RES_EMPTY;
      taken_q   <= 1'b0;
      cond_q    <= 4'd0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      flags_q   <= flags_d;
      state_q   <= state_d;
      taken_q   <= taken_d;
      cond_q    <= cond_d;
      err_q     <= err_d;
    end
  end

  assign o_r_valid     = (state_q == RES_FULL);
  assign o_r_taken     = taken_q;
  assign o_r_cond      = cond_q;
  assign o_flags       = flags_q;
  assign o_issue_stall = (pending_q == MAX_CNT);
  assign o_err         = err_q;

endmodule

// File: tb/tb_flag_eval.sv
// tb_flag_eval
// Directed bench for flag_eval with MAX_PENDING = 3. Inputs change 1 time
// unit after each rising edge; registered outputs are sampled there and
// o_q_ready is sampled one more unit later, after the inputs settle.
module tb_flag_eval;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_issue;
  logic       i_wb_valid;
  logic       i_wb_n, i_wb_z, i_wb_c, i_wb_v;
  logic       i_q_valid;
  logic       o_q_ready;
  logic [3:0] i_q_cond;
  logic       o_r_valid;
  logic       i_r_ready;
  logic       o_r_taken;
  logic [3:0] o_r_cond;
  logic [3:0] o_flags;
  logic       o_issue_stall;
  logic       o_err;

  int tests_run = 0;
  int tests_failed = 0;

  flag_eval #(.MAX_PENDING(3)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_issue       (i_issue),
    .i_wb_valid    (i_wb_valid),
    .i_wb_n        (i_wb_n),
    .i_wb_z        (i_wb_z),
    .i_wb_c        (i_wb_c),
    .i_wb_v        (i_wb_v),
    .i_q_valid     (i_q_valid),
    .o_q_ready     (o_q_ready),
    .i_q_cond      (i_q_cond),
    .o_r_valid     (o_r_valid),
    .i_r_ready     (i_r_ready),
    .o_r_taken     (o_r_taken),
    .o_r_cond      (o_r_cond),
    .o_flags       (o_flags),
    .o_issue_stall (o_issue_stall),
    .o_err         (o_err)
  );

  // Free-running clock, 10 time units per cycle.
  initial forever #5 i_clk = ~i_clk;

  // Drive every non-reset input at once; wb_nzcv is ordered {N,Z,C,V}.
  task automatic applyStimulus(input logic issue, input logic wb_valid,
                               input logic [3:0] wb_nzcv, input logic q_valid,
                               input logic [3:0] q_cond, input logic r_ready);
    i_issue    = issue;
    i_wb_valid = wb_valid;
    {i_wb_n, i_wb_z, i_wb_c, i_wb_v} = wb_nzcv;
    i_q_valid  = q_valid;
    i_q_cond   = q_cond;
    i_r_ready  = r_ready;
  endtask

  // One comparison: counts it and reports a mismatch with tag and values.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Check every output against its reset value.
  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " flags"},  8'(o_flags), 8'h0);
    checkOutput({tag, " r_valid"}, 8'(o_r_valid), 8'h0);
    checkOutput({tag, " r_taken"}, 8'(o_r_taken), 8'h0);
    checkOutput({tag, " r_cond"}, 8'(o_r_cond), 8'h0);
    checkOutput({tag, " err"}, 8'(o_err), 8'h0);
    checkOutput({tag, " stall"}, 8'(o_issue_stall), 8'h0);
  endtask

  logic [3:0] eq_conds [6] = '{4'd0, 4'd1, 4'd8, 4'd9, 4'd10, 4'd12};
  logic       eq_taken [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    // Reset, then an AL query in the first cycle out of reset.
    i_rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'd0, 1'b0);
    tick();
    tick();
    checkResetOutputs("reset");
    i_rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 4'd14, 1'b1);
    #1;
    checkOutput("al q_ready", 8'(o_q_ready), 8'h1);
    tick();
    checkOutput("al r_valid", 8'(o_r_valid), 8'h1);
    checkOutput("al r_taken", 8'(o_r_taken), 8'h1);
    checkOutput("al r_cond", 8'(o_r_cond), 8'd14);
    checkOutput("al flags", 8'(o_flags), 8'h0);

    // Equal compare: flags 0110, then a run of back-to-back queries.
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 4'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 4'b0110, 1'b0, 4'd0, 1'b1);
    tick();
    checkOutput("eq flags", 8'(o_flags), 8'b0110);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, eq_conds[i], 1'b1);
      tick();
      checkOutput($sformatf("eq cond%0d taken", eq_conds[i]), 8'(o_r_taken), 8'(eq_taken[i]));
      checkOutput($sformatf("eq cond%0d echo", eq_conds[i]), 8'(o_r_cond), 8'(eq_conds[i]));
    end
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'd0, 1'b1);
    tick();
    checkOutput("drain r_valid", 8'(o_r_valid), 8'h0);

    // Stall and bypass: HI blocked until the writeback, then sees new flags.
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 4'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 4'd8, 1'b1);
    for (int c = 1; c < 4; c++) begin
      #1;
      checkOutput($sformatf("stall c%0d q_ready", c), 8'(o_q_ready), 8'h0);
      tick();
      checkOutput($sformatf("stall c%0d r_valid", c), 8'(o_r_valid), 8'h0);
    end
    applyStimulus(1'b0, 1'b1, 4'b0010, 1'b1, 4'd8, 1'b1);
    #1;
    checkOutput("bypass q_ready", 8'(o_q_ready), 8'h1);
    tick();
    checkOutput("bypass r_valid", 8'(o_r_valid), 8'h1);
    checkOutput("bypass r_taken", 8'(o_r_taken), 8'h1);
    checkOutput("bypass flags", 8'(o_flags), 8'b0010);

    // Backpressure: held HI result stays stable, then a same-cycle reload.
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 4'd14, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput($sformatf("bp%0d q_ready", c), 8'(o_q_ready), 8'h0);
      tick();
      checkOutput($sformatf("bp%0d r_valid", c), 8'(o_r_valid), 8'h1);
      checkOutput($sformatf("bp%0d r_taken", c), 8'(o_r_taken), 8'h1);
      checkOutput($sformatf("bp%0d r_cond", c), 8'(o_r_cond), 8'd8);
    end
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 4'd15, 1'b1);
    #1;
    checkOutput("bp release q_ready", 8'(o_q_ready), 8'h1);
    tick();
    checkOutput("bp reload r_taken", 8'(o_r_taken), 8'h0);
    checkOutput("bp reload r_cond", 8'(o_r_cond), 8'd15);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'd0, 1'b1);
    tick();
    checkOutput("bp drain r_valid", 8'(o_r_valid), 8'h0);

    // Counter saturation at 3.
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 4'd0, 1'b1);
    tick();
    tick();
    checkOutput("sat2 stall", 8'(o_issue_stall), 8'h0);
    tick();
    checkOutput("sat3 stall", 8'(o_issue_stall), 8'h1);
    checkOutput("sat3 err", 8'(o_err), 8'h0);
    tick();
    checkOutput("sat4 stall", 8'(o_issue_stall), 8'h1);
    checkOutput("sat4 err", 8'(o_err), 8'h1);
    applyStimulus(1'b1, 1'b1, 4'b1001, 1'b0, 4'd0, 1'b1);
    tick();
    checkOutput("sat iss+wb stall", 8'(o_issue_stall), 8'h1);
    checkOutput("sat iss+wb flags", 8'(o_flags), 8'b1001);
    applyStimulus(1'b0, 1'b1, 4'b1001, 1'b0, 4'd0, 1'b1);
    tick();
    checkOutput("sat wb stall", 8'(o_issue_stall), 8'h0);

    // Clear the sticky error, then an orphan writeback.
    i_rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'd0, 1'b1);
    tick();
    checkOutput("rst err", 8'(o_err), 8'h0);
    i_rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 4'b1100, 1'b0, 4'd0, 1'b1);
    tick();
    checkOutput("orphan err", 8'(o_err), 8'h1);
    checkOutput("orphan flags", 8'(o_flags), 8'b1100);
    checkOutput("orphan stall", 8'(o_issue_stall), 8'h0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'd0, 1'b1);
    #1;
    checkOutput("orphan q_ready", 8'(o_q_ready), 8'h1);

    // Held result plus two in flight, then reset with a same-cycle issue.
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 4'd14, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 4'd0, 1'b0);
    tick();
    tick();
    checkOutput("pre-rst r_valid", 8'(o_r_valid), 8'h1);
    checkOutput("pre-rst r_taken", 8'(o_r_taken), 8'h1);
    i_rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 4'b1111, 1'b1, 4'd14, 1'b0);
    tick();
    checkResetOutputs("midrst");
    i_rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 4'd0, 1'b0);
    #1;
    checkOutput("midrst q_ready", 8'(o_q_ready), 8'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/flag_eval.md
# flag_eval

Condition-code consumer for the ALU flag path. It holds the architectural NZCV flag register written by the compare/subtract unit, and tracks how many flag-setting operations are still in flight. It evaluates 4-bit condition queries against the flags through a valid/ready handshake and returns a registered taken/not-taken result. It sits between the compare unit, which writes the flags, and the branch/predication logic, which consumes the result.

## Interface
- `MAX_PENDING`, default 3: maximum number of in-flight flag-setting ops, range 1..7.
- `i_clk`  in  1: clock; all state updates on the rising edge.
- `i_rst`  in  1: synchronous reset, active-high.
- `i_issue`  in  1: a flag-setting op was issued this cycle.
- `i_wb_valid`  in  1: flag writeback from the compare unit.
- `i_wb_n`, `i_wb_z`, `i_wb_c`, `i_wb_v`  in  1 each: written flags (negative, zero, carry, overflow).
- `i_q_valid`  in  1: condition query valid.
- `o_q_ready`  out  1: query accepted when `i_q_valid & o_q_ready`.
- `i_q_cond`  in  4: condition code.
- `o_r_valid`  out  1: result valid.
- `i_r_ready`  in  1: result consumed when `o_r_valid & i_r_ready`.
- `o_r_taken`  out  1: condition outcome.
- `o_r_cond`  out  4: echo of the evaluated condition code.
- `o_flags`  out  4: current flag register, ordered {N,Z,C,V}.
- `o_issue_stall`  out  1: high when `pending == MAX_PENDING`.
- `o_err`  out  1: sticky protocol error.

## Operation
- **Pending counter.** Width is `$clog2(MAX_PENDING+1)`.
  - `i_issue` alone increments it; `i_wb_valid` alone decrements it.
  - `i_issue` and `i_wb_valid` in the same cycle leave it unchanged.
- **Protocol errors.**
  - `i_issue` while `o_issue_stall` and no same-cycle writeback: the counter does not increment and `o_err` is set.
  - `i_wb_valid` with `pending == 0` and no same-cycle issue: the counter stays 0, the flags are still written, and `o_err` is set.
- **Flag register.** Loads `{i_wb_n,i_wb_z,i_wb_c,i_wb_v}` on every `i_wb_valid`.
- **Effective flags.** `flags_eff = i_wb_valid ? wb flags : flag register`, which gives a same-cycle bypass.
- **Ordering.** A same-cycle `i_issue` is younger than a same-cycle query and does not block it.
- **Query ready.** `o_q_ready = (pending == 0 || (pending == 1 && i_wb_valid)) && (!o_r_valid || i_r_ready)`.
- **Condition decode** against `flags_eff`:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - 10 GE: N==V
  - 11 LT: N!=V
  - 12 GT: !Z&(N==V)
  - 13 LE: Z|(N!=V)
  - 14 AL: 1
  - 15 NV: 0
- **Result register.**
  - Two states: EMPTY and FULL.
  - Accept in EMPTY → FULL, loading `o_r_taken` and `o_r_cond`.
  - FULL with `i_r_ready` and a new accept → stays FULL, reloaded.
  - FULL with `i_r_ready` and no accept → EMPTY.
  - FULL with `!i_r_ready` → holds; `o_r_taken` and `o_r_cond` stay stable.

## Timing
- **Reset values.** Flags 0000, pending 0, `o_r_valid` 0, `o_r_taken` 0, `o_r_cond` 0, `o_err` 0, `o_issue_stall` 0. `o_q_ready` reads 1 in the first cycle after reset.
- **Latency.** Query accepted in cycle t → `o_r_valid` in t+1. Throughput is one query per cycle while `i_r_ready` stays high.
- **Flag visibility.** A writeback in cycle t appears on `o_flags` in t+1. It is visible to a query in cycle t only through the bypass.
- **Combinational paths.** `o_q_ready` depends combinationally on `i_wb_valid` and `i_r_ready`. There is no combinational path from `i_q_valid` to any output.
- **Reset mid-operation.** Reset discards any pending count, held result and error. It takes priority over every same-cycle event.

## Structure
- **Package `flag_pkg`** holds:
  - the `cond_e` enum (16 codes above);
  - the `flags_t` packed struct {n,z,c,v};
  - the function `cond_pass(cond_e, flags_t)`.
- **Sub-module `cond_check`:** combinational wrapper around `cond_pass`, instantiated once on the `flags_eff` path.
- **Top module** holds the counter, flag register, result register and error logic.

## Test plan
- **Reset and AL query.** Reset, then query AL (14) with `i_r_ready` = 1 → `o_q_ready` 1, result next cycle `o_r_taken` 1, `o_r_cond` 14, `o_flags` 0000.
- **Equal compare.** Issue, then writeback N0 Z1 C1 V0 (5-5) → `o_flags` 0110. Queries then give: EQ 1, NE 0, HI 0, LS 1, GE 1, GT 0.
- **Stall and bypass.** Issue at cycle 0, query HI from cycle 1 → `o_q_ready` 0 until writeback N0 Z0 C1 V0 at cycle 4. The query is accepted in cycle 4 via the bypass, and `o_r_taken` is 1 at cycle 5.
- **Backpressure.** Result FULL with `i_r_ready` 0 for 3 cycles → `o_q_ready` 0, `o_r_taken`/`o_r_cond` stable. Raising `i_r_ready` accepts a new query in the same cycle.
- **Counter saturation.** `MAX_PENDING` = 3: three issues → `o_issue_stall` 1. A 4th issue is ignored and sets `o_err`. Issue plus writeback in the same cycle keeps pending at 3.
- **Orphan writeback and reset.** Writeback with pending 0 → `o_err` 1, flags updated. Then, with pending 2 and `o_r_valid` 1, assert `i_rst` → every output at its reset value next cycle.
